// File: rtl/two_way_cache_ctrl.sv
// Miss-handling controller for a two-way set-associative cache: hit/miss lookup,
// dirty-victim write-back burst, word-by-word refill and LRU update strobe.
module two_way_cache_ctrl #(
    parameter int unsigned ADDR_SIZE   = 32,
    parameter int unsigned NUM_SETS    = 16,
    parameter int unsigned BLOCK_WORDS = 4,
    localparam int unsigned WORD_BITS  = $clog2(BLOCK_WORDS),
    localparam int unsigned SET_BITS   = $clog2(NUM_SETS),
    localparam int unsigned TAG_SIZE   = ADDR_SIZE - 2 - WORD_BITS - SET_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 req_valid_i,
    input  logic                 req_we_i,
    input  logic [ADDR_SIZE-1:0] req_addr_i,
    output logic                 req_ready_o,
    output logic                 resp_valid_o,
    input  logic                 hit_i,
    input  logic                 victim_dirty_i,
    input  logic [TAG_SIZE-1:0]  victim_tag_i,
    output logic [ADDR_SIZE-1:0] arr_addr_o,
    output logic                 arr_we_o,
    output logic                 fill_we_o,
    output logic                 lru_replace_o,
    output logic                 mem_req_valid_o,
    output logic                 mem_req_we_o,
    output logic [ADDR_SIZE-1:0] mem_req_addr_o,
    input  logic                 mem_req_ready_i,
    input  logic                 mem_rvalid_i
);

    localparam int unsigned WordLsb = 2;
    localparam int unsigned SetLsb  = WordLsb + WORD_BITS;
    localparam int unsigned TagLsb  = SetLsb + SET_BITS;
    localparam logic [WORD_BITS-1:0] LastWord = WORD_BITS'(BLOCK_WORDS - 1);

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWbReq,
        StRfReq,
        StRfWait,
        StDone
    } state_e;

    state_e                 state_q, state_d;
    logic [WORD_BITS-1:0]   cnt_q, cnt_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic                   we_q, we_d;

    logic [TAG_SIZE-1:0]    latched_tag;
    logic [SET_BITS-1:0]    latched_set;

    assign latched_tag = addr_q[ADDR_SIZE-1:TagLsb];
    assign latched_set = addr_q[TagLsb-1:SetLsb];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            addr_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            we_q    <= we_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        we_d    = we_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    addr_d  = req_addr_i;
                    we_d    = req_we_i;
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (hit_i) begin
                    state_d = StIdle;
                end else if (victim_dirty_i) begin
                    state_d = StWbReq;
                end else begin
                    state_d = StRfReq;
                end
            end
            StWbReq: begin
                if (mem_req_ready_i) begin
                    if (cnt_q == LastWord) begin
                        cnt_d   = '0;
                        state_d = StRfReq;
                    end else begin
                        cnt_d = cnt_q + WORD_BITS'(1);
                    end
                end
            end
            StRfReq: begin
                if (mem_req_ready_i) begin
                    state_d = StRfWait;
                end
            end
            StRfWait: begin
                if (mem_rvalid_i) begin
                    if (cnt_q != LastWord) begin
                        cnt_d   = cnt_q + WORD_BITS'(1);
                        state_d = StRfReq;
                    end else begin
                        cnt_d   = '0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                // Replay the original request; the freshly filled way now hits.
                state_d = StLookup;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        req_ready_o     = 1'b0;
        resp_valid_o    = 1'b0;
        arr_we_o        = 1'b0;
        fill_we_o       = 1'b0;
        lru_replace_o   = 1'b0;
        mem_req_valid_o = 1'b0;
        mem_req_we_o    = 1'b0;
        mem_req_addr_o  = '0;
        arr_addr_o      = addr_q;
        unique case (state_q)
            StIdle: begin
                req_ready_o = 1'b1;
            end
            StLookup: begin
                resp_valid_o = hit_i;
                arr_we_o     = hit_i & we_q;
            end
            StWbReq: begin
                mem_req_valid_o                 = 1'b1;
                mem_req_we_o                    = 1'b1;
                mem_req_addr_o                  = {victim_tag_i, latched_set, cnt_q, 2'b00};
                arr_addr_o[SetLsb-1:WordLsb]    = cnt_q;
            end
            StRfReq: begin
                mem_req_valid_o                 = 1'b1;
                mem_req_addr_o                  = {latched_tag, latched_set, cnt_q, 2'b00};
                arr_addr_o[SetLsb-1:WordLsb]    = cnt_q;
            end
            StRfWait: begin
                fill_we_o                       = mem_rvalid_i;
                arr_addr_o[SetLsb-1:WordLsb]    = cnt_q;
            end
            StDone: begin
                lru_replace_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/two_way_cache_ctrl.md
TWO_WAY_CACHE_CTRL -- requirements
Module: two_way_cache_ctrl

Interface
REQ-001 The block SHALL have parameters: ADDR_SIZE, 32, address width; NUM_SETS, 16, sets per way; BLOCK_WORDS, 4, 32-bit words per block.
REQ-002 Address fields SHALL be: bits[1:0] byte, then $clog2(BLOCK_WORDS) word index, then $clog2(NUM_SETS) set, with the remaining upper bits forming the tag (defaults: [3:2] word, [7:4] set, [31:8] tag).
REQ-003 The block SHALL have the following ports:
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset; asynchronous, active-low
- req_valid  input  1  CPU request
- req_we  input  1  1 = store, 0 = load
- req_addr  input  ADDR_SIZE  CPU address
- req_ready  output  1  request accepted this cycle
- resp_valid  output  1  one-cycle completion pulse
- hit  input  1  tag match from arrays (valid in LOOKUP)
- victim_dirty  input  1  dirty bit of the LRU-preferred way
- victim_tag  input  TAG_SIZE  tag of the LRU-preferred way
- arr_addr  output  ADDR_SIZE  array index: latched address, with the word field replaced by the counter in WB/RF states
- arr_we  output  1  store-hit write strobe
- fill_we  output  1  refill word write into the preferred way
- lru_replace  output  1  LRU toggle strobe for the set of arr_addr
- mem_req_valid  output  1  memory request
- mem_req_we  output  1  memory write
- mem_req_addr  output  ADDR_SIZE  word-aligned memory address
- mem_req_ready  input  1  memory accepts request
- mem_rvalid  input  1  read data returned (data carried outside the block)

Function
REQ-004 The FSM SHALL implement the states IDLE, LOOKUP, WB_REQ, RF_REQ, RF_WAIT and DONE.
REQ-005 IDLE behaviour:
- req_ready=1.
- On req_valid, latch req_addr and req_we, then go to LOOKUP.
REQ-006 LOOKUP outcomes:
- hit=1: resp_valid=1 and arr_we=req_we_latched this cycle, then go to IDLE.
- hit=0 with victim_dirty=1: go to WB_REQ.
- hit=0 with victim_dirty=0: go to RF_REQ.
REQ-007 WB_REQ behaviour:
- Drive mem_req_valid=1, mem_req_we=1, mem_req_addr={victim_tag, set, cnt, 2'b00}.
- On each mem_req_ready, increment cnt.
- At cnt=BLOCK_WORDS-1 with mem_req_ready: clear cnt and go to RF_REQ.
REQ-008 RF_REQ behaviour:
- Drive mem_req_valid=1, mem_req_we=0, mem_req_addr={tag, set, cnt, 2'b00}.
- On mem_req_ready, go to RF_WAIT.
REQ-009 RF_WAIT behaviour:
- On mem_rvalid, drive fill_we=1 that cycle.
- If cnt<BLOCK_WORDS-1: increment cnt and go to RF_REQ.
- Otherwise: clear cnt and go to DONE.
REQ-010 DONE behaviour:
- Drive lru_replace=1 for exactly one cycle.
- Go to LOOKUP to replay the request, which SHALL hit.
REQ-011 Single-outstanding rule: the block SHALL have at most one memory read outstanding, and mem_req_valid SHALL stay high with address stable until mem_req_ready.
REQ-012 Strobe exclusivity: resp_valid, arr_we, fill_we and lru_replace SHALL be single-cycle strobes, never asserted outside their states.
REQ-013 LRU update policy: lru_replace SHALL assert only on refill completion, never on a hit.
REQ-014 Counter width: cnt SHALL be $clog2(BLOCK_WORDS) bits and SHALL wrap to 0 only via the explicit clears.
REQ-015 Input sampling:
- req_valid outside IDLE SHALL be ignored (req_ready=0).
- mem_rvalid outside RF_WAIT SHALL be ignored.
- mem_req_ready with mem_req_valid=0 SHALL be ignored.

Reset
REQ-016 Reset values: asserting rst low SHALL asynchronously force state=IDLE, cnt=0, latched address/we=0, and all strobes and mem_req_valid=0; req_ready=1.
REQ-017 Reset mid-operation: reset in any state, including mid-burst, SHALL abandon the transaction with no further memory request after deassertion.

Verification
REQ-018 Read hit: req addr 0x0000_0140, hit=1 -> resp_valid on 2nd cycle after acceptance; no mem_req_valid; lru_replace=0.
REQ-019 Clean miss:
- Stimulus: addr 0x1234_5678, hit=0, victim_dirty=0, mem_req_ready=1, mem_rvalid one cycle after each request.
- Required response: 4 reads to 0x1234_5670/74/78/7C; 4 fill_we pulses; one lru_replace; then resp_valid.
REQ-020 Dirty miss:
- Stimulus: victim_tag 0xABCDEF, set 7.
- Required response: 4 writes to 0xABCD_EF70..7C precede any read; then refill as in REQ-019.
REQ-021 Backpressure: mem_req_ready low 5 cycles -> mem_req_valid and mem_req_addr held constant throughout.
REQ-022 Reset during refill word 2 -> all outputs at reset values immediately; next request restarts at cnt=0.
REQ-023 Store hit: req_we=1, hit=1 -> arr_we and resp_valid pulse together in LOOKUP; no memory traffic.
